rng_harvest: RTL and testbench
==============================

# rng_harvest

Downstream consumer of the cellular-automaton entropy state in the RNG path. Samples the free-running `WIDTH`-bit CA state, discards a warm-up window, XOR-decimates `DECIM` consecutive states into one output word, and runs a repetition-count health test on each word. Passing words go into a small show-ahead FIFO. The FIFO is drained by a valid/ready consumer such as the crypto core or a bus register.

## Interface
- `WIDTH`, 32: CA state and output word width.
- `DECIM`, 4: CA states XOR-folded per output word; ≥1.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WARMUP`, 64: cycles of CA state discarded after each enable; 0 allowed.
- `REP_LIMIT`, 3: identical consecutive candidate words that trip the health test; ≥2.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset, asynchronous assert, active-low; `rst=0` resets everything.
- `en`, in, 1: harvest enable, level-sensitive.
- `ca_state`, in, `WIDTH`: CA state, sampled every cycle.
- `clr_fail`, in, 1: single-cycle pulse; clears the health failure.
- `rnd_data`, out, `WIDTH`: FIFO head word; all zeros when the FIFO is empty.
- `rnd_valid`, out, 1: FIFO non-empty.
- `rnd_ready`, in, 1: consumer accept; a pop occurs when `rnd_valid & rnd_ready`.
- `health_fail`, out, 1: sticky health-test failure.
- `level`, out, `$clog2(DEPTH)+1`: FIFO occupancy.
- `drop_cnt`, out, 8: saturating count of words dropped because the FIFO was full.

## Operation
- **FSM states:** IDLE, WARMUP, RUN, FAIL. Reset state is IDLE.
- **IDLE:**
  - `en=1` → WARMUP (wcnt=0), or → RUN if `WARMUP=0`.
  - Accumulator `acc` and phase counter are held at 0.
- **WARMUP:**
  - `ca_state` is ignored; wcnt increments each cycle.
  - wcnt==`WARMUP`-1 → RUN with phase=0 and acc=0.
- **RUN, each cycle:**
  - cand = acc ^ `ca_state`.
  - phase<`DECIM`-1: acc←cand, phase++.
  - phase==`DECIM`-1: cand is the candidate word; acc←0, phase←0.
- **Health test, per candidate:**
  - Reference: `last` register plus `last_vld` flag.
  - cand==`last` with `last_vld`=1 → rep++; otherwise rep←1.
  - `last`←cand, `last_vld`←1.
  - If the new rep==`REP_LIMIT`: the candidate is not pushed, `health_fail`←1, FIFO is flushed, FSM → FAIL.
- **Push:**
  - A passing candidate is written at the FIFO tail.
  - If the FIFO is full and there is no pop in the same cycle, the word is dropped and `drop_cnt` increments, saturating at 255.
  - Dropped words still update the health-test state.
- **FAIL:**
  - No harvesting; FIFO stays empty; `en` is ignored.
  - `clr_fail=1` → IDLE. This clears `health_fail`, `last_vld`, rep, acc and phase.
  - `clr_fail` has no effect outside FAIL.
- **`en` falls in WARMUP or RUN:**
  - → IDLE next cycle; a partial acc is discarded.
  - FIFO contents are retained and still drainable.
  - `last_vld` and rep are retained.
  - Re-asserting `en` repeats the full warm-up.
- **FIFO arithmetic:**
  - Pointers wrap modulo `DEPTH`.
  - `level` ranges 0..`DEPTH`; full when `level`==`DEPTH`.

## Timing
- Reset values: `rnd_data`=0, `rnd_valid`=0, `health_fail`=0, `level`=0, `drop_cnt`=0, FSM=IDLE, pointers/acc/phase/wcnt/rep/`last_vld`=0.
- Asynchronous assertion of `rst` mid-operation immediately clears all state, including the FIFO.
- Push latency: a candidate formed at the edge where phase==`DECIM`-1 is visible on `rnd_valid`/`rnd_data` right after that edge.
- Pop: `rnd_valid & rnd_ready` at edge N. After edge N, `rnd_data` shows the next entry (or 0), and `level` decrements unless there was a simultaneous push.
- Simultaneous push and pop:
  - FIFO not full: `level` unchanged.
  - FIFO full: the push is accepted, `level` stays `DEPTH`, nothing is dropped.
  - FIFO empty: the pushed word appears the cycle after the push edge. There is no bypass.
- Flush on FAIL entry beats a simultaneous pop: `level`=0 after the edge.
- Start-up latency: count the edge that first samples `en=1` in IDLE as edge 0. WARMUP occupies edges 1..`WARMUP`, RUN starts at edge `WARMUP`+1, and the first push is at edge `WARMUP`+`DECIM`. With defaults, `rnd_valid` rises after edge 68.
- Throughput: one word per `DECIM` cycles in steady state.

## Test plan
- **Start-up and throughput.** Defaults; `ca_state`=cycle count; `en`=1 from edge 0; `rnd_ready`=1.
  - `rnd_valid` first rises after edge 68.
  - Each word equals the XOR of the 4 sampled states.
  - A new word arrives every 4 cycles.
- **FIFO full and drop.** `rnd_ready`=0, varying `ca_state`.
  - `level` reaches 4; the next candidate increments `drop_cnt` to 1.
  - `drop_cnt` saturates at 255 after a long run.
  - A pop coinciding with a push at full leaves `level`=4 with no drop.
- **Health failure.** Constant `ca_state`=32'hA5A5A5A5, so every candidate is 0.
  - Words 1 and 2 (value 0) are pushed.
  - The 3rd candidate sets `health_fail`=1 and flushes the FIFO (`level`=0, `rnd_valid`=0).
- **Recovery.** While in FAIL, toggle `en` → no effect. Pulse `clr_fail` → `health_fail`=0 and FSM goes to IDLE. With `en` still 1, the flow restarts warm-up and the first word arrives 68 edges later.
- **Enable drop.** Deassert `en` mid-RUN with the partial acc non-zero.
  - FIFO entries remain and drain normally.
  - On re-enable, the first word excludes all pre-drop samples.
- **Async reset.** Assert `rst`=0 between edges with `level`=3 and `drop_cnt`=5. All outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rng_harvest.sv
// rng_harvest: XOR-decimates the free-running CA state into words and runs a
// repetition-count health test on each one. Passing words are buffered in a show-ahead FIFO.
module rng_harvest #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DECIM     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WARMUP    = 64,
    parameter int unsigned REP_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       ca_state,
    input  logic                   clr_fail,
    output logic [WIDTH-1:0]       rnd_data,
    output logic                   rnd_valid,
    input  logic                   rnd_ready,
    output logic                   health_fail,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drop_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned WC_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAIL} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, cand, last;
    logic [PH_W-1:0]  phase, phase_nxt;
    logic [WC_W-1:0]  wcnt, wcnt_nxt;
    logic [REP_W-1:0] rep, rep_nxt;
    logic             last_vld;
    logic             cand_vld, fail_hit, clear_health;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             full, pop, push, drop;

    // Harvest FSM: warm-up, decimation phase and health-test decision
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        phase_nxt    = phase;
        wcnt_nxt     = wcnt;
        cand         = acc ^ ca_state;
        cand_vld     = 1'b0;
        fail_hit     = 1'b0;
        clear_health = 1'b0;
        rep_nxt      = (last_vld && (cand == last)) ? rep + REP_W'(1) : REP_W'(1);
        case (state)
            S_IDLE: begin
                acc_nxt   = '0;
                phase_nxt = '0;
                wcnt_nxt  = '0;
                if (en) state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
            end
            S_WARMUP: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                    wcnt_nxt  = '0;
                end else if (32'(wcnt) == WARMUP - 1) begin
                    state_nxt = S_RUN;
                    wcnt_nxt  = '0;
                    acc_nxt   = '0;
                    phase_nxt = '0;
                end else begin
                    wcnt_nxt = wcnt + WC_W'(1);
                end
            end
            S_RUN: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                    acc_nxt   = '0;
                    phase_nxt = '0;
                end else if (32'(phase) == DECIM - 1) begin
                    cand_vld  = 1'b1;
                    acc_nxt   = '0;
                    phase_nxt = '0;
                    if (32'(rep_nxt) == REP_LIMIT) begin
                        fail_hit  = 1'b1;
                        state_nxt = S_FAIL;
                    end
                end else begin
                    acc_nxt   = cand;
                    phase_nxt = phase + PH_W'(1);
                end
            end
            S_FAIL: begin
                acc_nxt   = '0;
                phase_nxt = '0;
                if (clr_fail) begin
                    state_nxt    = S_IDLE;
                    clear_health = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; a health failure flushes and wins over any pop
    always_comb begin
        full      = (level == LVL_W'(DEPTH));
        pop       = rnd_valid & rnd_ready;
        push      = cand_vld & ~fail_hit & (~full | pop);
        drop      = cand_vld & ~fail_hit & full & ~pop;
        rd_nxt    = rd_ptr + PTR_W'(pop);
        wr_nxt    = wr_ptr + PTR_W'(push);
        level_nxt = level + LVL_W'(push) - LVL_W'(pop);
        head_nxt  = '0;
        if (fail_hit) begin
            rd_nxt    = '0;
            wr_nxt    = '0;
            level_nxt = '0;
        end
        if (level_nxt != '0) head_nxt = (push && (wr_ptr == rd_nxt)) ? cand : mem[rd_nxt];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            acc   <= '0;
            phase <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            phase <= phase_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Health-test reference; dropped words still update it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last        <= '0;
            last_vld    <= 1'b0;
            rep         <= '0;
            health_fail <= 1'b0;
        end else if (clear_health) begin
            last_vld    <= 1'b0;
            rep         <= '0;
            health_fail <= 1'b0;
        end else if (cand_vld) begin
            last     <= cand;
            last_vld <= 1'b1;
            rep      <= rep_nxt;
            if (fail_hit) health_fail <= 1'b1;
        end
    end

    // Registered FIFO head and status so outputs never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            drop_cnt  <= '0;
        end else begin
            rd_ptr    <= rd_nxt;
            wr_ptr    <= wr_nxt;
            level     <= level_nxt;
            rnd_valid <= (level_nxt != '0);
            rnd_data  <= head_nxt;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cand;
    end

endmodule

// File: tb/tb_rng_harvest.sv
// tb_rng_harvest: table vectors plus scoreboard-checked sequences for rng_harvest
// with default parameters (WIDTH=32, DECIM=4, DEPTH=4, WARMUP=64, REP_LIMIT=3).
module tb_rng_harvest;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        clr_fail = 1'b0;
    logic        rnd_ready = 1'b0;
    logic [31:0] ca_state = '0;
    logic [31:0] rnd_data;
    logic        rnd_valid;
    logic        health_fail;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] sb [$];
    int exp_level = 0;
    int exp_drop = 0;

    typedef struct {
        logic [31:0] s0, s1, s2, s3;
        logic [31:0] word;
        int          lvl;
        int          drop;
    } vec_t;
    vec_t tab [6];

    always #5 clk = ~clk;

    rng_harvest dut (
        .clk(clk), .rst(rst), .en(en), .ca_state(ca_state), .clr_fail(clr_fail),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .health_fail(health_fail), .level(level), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; clr_fail = 1'b0; rnd_ready = 1'b0; ca_state = '0;
        step();
        step();
        rst = 1'b1;
        sb.delete();
        exp_level = 0;
        exp_drop = 0;
    endtask

    // Edge 0 samples en in IDLE; edges 1..64 are warm-up; returns phase-aligned in RUN
    task automatic start();
        en = 1'b1;
        for (int e = 0; e < 65; e++) begin
            ca_state = $urandom;
            step();
        end
        chk("warmup_quiet", 32'(rnd_valid), 32'(exp_level != 0));
    endtask

    task automatic run_word(input logic [31:0] a, b, c, d, input logic pop);
        logic [31:0] s [4];
        logic [31:0] e;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < 4; i++) begin
            ca_state = s[i];
            rnd_ready = (i == 3) && pop;
            if ((i == 3) && pop) begin
                e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
                chk("pop_head", rnd_data, e);
                exp_level--;
            end
            step();
        end
        rnd_ready = 1'b0;
        if (exp_level < 4) begin
            sb.push_back(a ^ b ^ c ^ d);
            exp_level++;
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    // Drain with en low so no new words arrive
    task automatic drain();
        logic [31:0] e;
        en = 1'b0;
        rnd_ready = 1'b1;
        while (exp_level > 0) begin
            e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
            chk("drain_valid", 32'(rnd_valid), 32'd1);
            chk("drain_data", rnd_data, e);
            step();
            exp_level--;
        end
        rnd_ready = 1'b0;
        chk("drain_empty", 32'(rnd_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] acc_m;
        logic [31:0] samp [69];
        logic        exp_v;

        tab[0] = '{32'h1,        32'h2,        32'h4, 32'h8, 32'h0000000F, 1, 0};
        tab[1] = '{32'h10,       32'h20,       32'h40, 32'h80, 32'h000000F0, 2, 0};
        tab[2] = '{32'h100,      32'h200,      32'h400, 32'h800, 32'h00000F00, 3, 0};
        tab[3] = '{32'h1000,     32'h2000,     32'h4000, 32'h8000, 32'h0000F000, 4, 0};
        tab[4] = '{32'hFFFF0000, 32'h0000FFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 4, 1};
        tab[5] = '{32'h12345678, 32'h12345678, 32'h0, 32'h1, 32'h00000001, 4, 2};

        // Reset state
        @(negedge clk);
        chk("rst_data", rnd_data, 32'h0);
        chk("rst_valid", 32'(rnd_valid), 32'd0);
        chk("rst_fail", 32'(health_fail), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Start-up latency and throughput, ca_state = edge index
        do_reset();
        rnd_ready = 1'b1;
        en = 1'b1;
        acc_m = '0;
        for (int e = 0; e <= 84; e++) begin
            ca_state = 32'(e);
            step();
            if (e >= 65) acc_m ^= 32'(e);
            exp_v = (e >= 68) && (((e - 68) % 4) == 0);
            if (exp_v) begin
                sb.push_back(acc_m);
                acc_m = '0;
            end
            chk("start_valid", 32'(rnd_valid), 32'(exp_v));
            if (exp_v) chk("start_word", rnd_data, sb.pop_front());
        end

        // FIFO fill and drop from the vector table
        do_reset();
        start();
        for (int k = 0; k < 6; k++) begin
            run_word(tab[k].s0, tab[k].s1, tab[k].s2, tab[k].s3, 1'b0);
            chk("tab_level", 32'(level), 32'(tab[k].lvl));
            chk("tab_drop", 32'(drop_cnt), 32'(tab[k].drop));
            chk("tab_head", rnd_data, tab[0].word);
        end
        run_word($urandom, $urandom, $urandom, $urandom, 1'b1);
        chk("full_pushpop_level", 32'(level), 32'd4);
        chk("full_pushpop_drop", 32'(drop_cnt), 32'd2);
        chk("full_pushpop_head", rnd_data, tab[1].word);
        for (int k = 0; k < 260; k++) run_word($urandom, $urandom, $urandom, $urandom, 1'b0);
        chk("drop_saturate", 32'(drop_cnt), 32'd255);
        chk("drop_sat_level", 32'(level), 32'd4);
        drain();

        // Health failure: constant state makes every candidate zero
        do_reset();
        start();
        run_word(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        run_word(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        chk("hf_level2", 32'(level), 32'd2);
        chk("hf_valid", 32'(rnd_valid), 32'd1);
        chk("hf_data0", rnd_data, 32'h0);
        chk("hf_not_yet", 32'(health_fail), 32'd0);
        for (int i = 0; i < 4; i++) begin
            ca_state = 32'hA5A5A5A5;
            rnd_ready = (i == 3);
            step();
        end
        rnd_ready = 1'b0;
        sb.delete();
        exp_level = 0;
        chk("hf_set", 32'(health_fail), 32'd1);
        chk("hf_flush_level", 32'(level), 32'd0);
        chk("hf_flush_valid", 32'(rnd_valid), 32'd0);
        chk("hf_flush_data", rnd_data, 32'h0);

        // Recovery: en ignored in FAIL, clr_fail restarts full warm-up
        for (int i = 0; i < 6; i++) begin
            en = ((i % 2) == 0) ? 1'b0 : 1'b1;
            ca_state = $urandom;
            step();
            chk("fail_sticky", 32'(health_fail), 32'd1);
            chk("fail_empty", 32'(rnd_valid), 32'd0);
        end
        en = 1'b1;
        clr_fail = 1'b1;
        step();
        clr_fail = 1'b0;
        chk("clr_fail", 32'(health_fail), 32'd0);
        acc_m = '0;
        for (int e = 0; e <= 68; e++) begin
            samp[e] = $urandom;
            ca_state = samp[e];
            step();
            if (e >= 65) acc_m ^= samp[e];
            if (e >= 60) chk("recover_valid", 32'(rnd_valid), 32'(e == 68));
        end
        chk("recover_word", rnd_data, acc_m);

        // Enable drop mid-RUN discards the partial accumulation
        do_reset();
        start();
        run_word(32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
        ca_state = 32'hDEADBEEF; step();
        ca_state = 32'h12345678; step();
        en = 1'b0;
        ca_state = 32'hCAFEF00D; step();
        chk("endrop_level", 32'(level), 32'd1);
        chk("endrop_head", rnd_data, 32'h00000044);
        drain();
        start();
        run_word(32'h5, 32'h6, 32'h7, 32'h9, 1'b0);
        chk("reen_word", rnd_data, 32'h0000000D);
        chk("reen_level", 32'(level), 32'd1);

        // Async reset with level=3, drop_cnt=5
        do_reset();
        start();
        for (int k = 0; k < 9; k++) run_word($urandom, $urandom, $urandom, $urandom, 1'b0);
        en = 1'b0;
        rnd_ready = 1'b1;
        step();
        rnd_ready = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_drop", 32'(drop_cnt), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_data", rnd_data, 32'h0);
        chk("arst_valid", 32'(rnd_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_fail", 32'(health_fail), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
